// File: rtl/imem_uart_loader.sv
// UART program loader: receives an A5/N/data/checksum frame and writes it word by word
// into instruction memory, holding the CPU until a checksum-valid image is loaded.
module imem_uart_loader #(
  parameter int CLK_HZ       = 100000000,
  parameter int BAUD         = 115200,
  parameter int ADDR_W       = 7,
  parameter int TIMEOUT_BITS = 1000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_rx,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [7:0]        word_count
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CYC  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int MAX_WORDS    = 1 << ADDR_W;
  localparam int TMR_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {F_IDLE, F_COUNT, F_DATA, F_CSUM, F_ERR} frame_state_t;

  // rx_prev gives a one-cycle history of the synchronised line for falling-edge detection
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_t        rx_state_reg, rx_state_next;
  logic [TMR_W-1:0] bit_tmr_reg, bit_tmr_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       rx_shift_reg, rx_shift_next;
  logic             byte_valid, frame_err;

  always_comb begin
    rx_state_next = rx_state_reg;
    bit_tmr_next  = bit_tmr_reg;
    bit_idx_next  = bit_idx_reg;
    rx_shift_next = rx_shift_reg;
    byte_valid    = 1'b0;
    frame_err     = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_next = RX_START;
          bit_tmr_next  = '0;
        end
      end
      RX_START: begin
        if (bit_tmr_reg == TMR_W'(HALF_BIT - 1)) begin
          bit_tmr_next  = '0;
          bit_idx_next  = '0;
          rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          bit_tmr_next = bit_tmr_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_tmr_reg == TMR_W'(CLKS_PER_BIT - 1)) begin
          bit_tmr_next  = '0;
          rx_shift_next = {rx_sync, rx_shift_reg[7:1]};
          bit_idx_next  = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) rx_state_next = RX_STOP;
        end else begin
          bit_tmr_next = bit_tmr_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (bit_tmr_reg == TMR_W'(CLKS_PER_BIT - 1)) begin
          rx_state_next = RX_IDLE;
          byte_valid    = rx_sync;
          frame_err     = !rx_sync;
        end else begin
          bit_tmr_next = bit_tmr_reg + 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state_reg <= RX_IDLE;
      bit_tmr_reg  <= '0;
      bit_idx_reg  <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      bit_tmr_reg  <= bit_tmr_next;
      bit_idx_reg  <= bit_idx_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  frame_state_t      state_reg, state_next;
  logic [7:0]        n_reg, n_next;
  logic [1:0]        lane_reg, lane_next;
  logic [23:0]       word_reg, word_next;
  logic [7:0]        csum_reg, csum_next;
  logic [TO_W-1:0]   to_reg, to_next;
  logic              we_reg, we_next, done_reg, done_next, err_reg, err_next, hold_reg, hold_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [7:0]        wcnt_reg, wcnt_next;
  logic              in_frame, abort;

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    lane_next  = lane_reg;
    word_next  = word_reg;
    csum_next  = csum_reg;
    we_next    = 1'b0;
    done_next  = 1'b0;
    err_next   = err_reg;
    hold_next  = hold_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wcnt_next  = wcnt_reg;
    in_frame   = (state_reg == F_COUNT) || (state_reg == F_DATA) || (state_reg == F_CSUM);
    to_next    = (in_frame && !byte_valid) ? to_reg + 1'b1 : '0;
    // Mid-frame line faults: a bad stop bit or the line going quiet too long
    abort      = in_frame && (frame_err || to_reg == TO_W'(TIMEOUT_CYC - 1));

    if (abort) begin
      state_next = F_ERR;
      err_next   = 1'b1;
      hold_next  = 1'b1;
    end else if (byte_valid) begin
      case (state_reg)
        F_IDLE, F_ERR: begin
          if (rx_shift_reg == SYNC_BYTE) begin
            state_next = F_COUNT;
            lane_next  = '0;
            csum_next  = '0;
            wcnt_next  = '0;
            err_next   = 1'b0;
          end
        end
        F_COUNT: begin
          if (rx_shift_reg == 8'd0 || int'(rx_shift_reg) > MAX_WORDS) begin
            state_next = F_ERR;
            err_next   = 1'b1;
            hold_next  = 1'b1;
          end else begin
            n_next     = rx_shift_reg;
            hold_next  = 1'b1;
            state_next = F_DATA;
          end
        end
        F_DATA: begin
          csum_next = csum_reg ^ rx_shift_reg;
          lane_next = lane_reg + 1'b1;
          if (lane_reg == 2'd3) begin
            we_next    = 1'b1;
            addr_next  = ADDR_W'(wcnt_reg);
            wdata_next = {rx_shift_reg, word_reg};
            wcnt_next  = wcnt_reg + 8'd1;
            if (wcnt_reg + 8'd1 == n_reg) state_next = F_CSUM;
          end else begin
            word_next = {rx_shift_reg, word_reg[23:8]};
          end
        end
        F_CSUM: begin
          if (rx_shift_reg == csum_reg) begin
            done_next  = 1'b1;
            hold_next  = 1'b0;
            state_next = F_IDLE;
          end else begin
            state_next = F_ERR;
            err_next   = 1'b1;
            hold_next  = 1'b1;
          end
        end
        default: state_next = F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= F_IDLE;
      n_reg     <= '0;
      lane_reg  <= '0;
      word_reg  <= '0;
      csum_reg  <= '0;
      to_reg    <= '0;
      we_reg    <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      hold_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      lane_reg  <= lane_next;
      word_reg  <= word_next;
      csum_reg  <= csum_next;
      to_reg    <= to_next;
      we_reg    <= we_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      hold_reg  <= hold_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wcnt_reg  <= wcnt_next;
    end
  end

  assign im_we      = we_reg;
  assign im_addr    = addr_reg;
  assign im_wdata   = wdata_reg;
  assign cpu_hold   = hold_reg;
  assign load_done  = done_reg;
  assign load_err   = err_reg;
  assign word_count = wcnt_reg;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: drives 8N1 frames at 10 clk/bit and checks writes,
// hold/done/error flags, timeout timing and asynchronous reset behaviour.
module tb_imem_uart_loader;
  localparam int CLK_HZ = 1000000, BAUD = 100000, ADDR_W = 7, TIMEOUT_BITS = 1000;
  localparam int CPB = 10;

  logic              clk = 1'b0, rstn = 1'b0, uart_rx = 1'b1;
  logic              im_we, cpu_hold, load_done, load_err;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [7:0]        word_count;

  always #5 clk = ~clk;

  imem_uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
    .clk(clk), .rstn(rstn), .uart_rx(uart_rx), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .word_count(word_count)
  );

  int n_checks = 0, n_errors = 0;
  int we_cnt = 0, done_cnt = 0, we_base = 0, done_base = 0;
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0]  tx_q [$];

  // Observe the IM write port and done strobe; the stimulus only reads these
  always @(negedge clk) begin
    if (rstn) begin
      if (im_we) begin
        mem[im_addr] = im_wdata;
        we_cnt++;
      end
      if (load_done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
  endtask

  task automatic mark();
    we_base   = we_cnt;
    done_base = done_cnt;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(im_we), 0);
    check({tag, "_addr"},  32'(im_addr), 0);
    check({tag, "_wdata"}, im_wdata, 0);
    check({tag, "_hold"},  32'(cpu_hold), 0);
    check({tag, "_done"},  32'(load_done), 0);
    check({tag, "_err"},   32'(load_err), 0);
    check({tag, "_wcnt"},  32'(word_count), 0);
  endtask

  initial begin
    int cyc;
    #1 check_reset_outputs("rst_in");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_out");

    // Good two-word frame, checksum 0xC0
    mark();
    tx_q = {8'hA5, 8'h02};
    send_q();
    check("good_hold_loading", 32'(cpu_hold), 1);
    tx_q = {8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
    send_q();
    repeat (5) @(negedge clk);
    check("good_we_cnt", 32'(we_cnt - we_base), 2);
    check("good_mem0", mem[0], 32'h00500013);
    check("good_mem1", mem[1], 32'h00100093);
    check("good_done_cnt", 32'(done_cnt - done_base), 1);
    check("good_hold", 32'(cpu_hold), 0);
    check("good_wcnt", 32'(word_count), 2);
    check("good_err", 32'(load_err), 0);

    // Same frame with a wrong checksum, then the correct frame again
    mark();
    tx_q = {8'hA5, 8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    send_q();
    repeat (5) @(negedge clk);
    check("badcs_we_cnt", 32'(we_cnt - we_base), 2);
    check("badcs_err", 32'(load_err), 1);
    check("badcs_hold", 32'(cpu_hold), 1);
    check("badcs_done_cnt", 32'(done_cnt - done_base), 0);
    mark();
    send_byte(8'hA5, 1'b1);
    check("resend_err_cleared", 32'(load_err), 0);
    tx_q = {8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
    send_q();
    repeat (5) @(negedge clk);
    check("resend_done_cnt", 32'(done_cnt - done_base), 1);
    check("resend_hold", 32'(cpu_hold), 0);

    // Noise bytes and a short glitch in IDLE, then a one-word frame (0xDEADBEEF, csum 0x22)
    mark();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    check("noise_we_cnt", 32'(we_cnt - we_base), 0);
    check("noise_hold", 32'(cpu_hold), 0);
    check("noise_err", 32'(load_err), 0);
    tx_q = {8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_q();
    repeat (5) @(negedge clk);
    check("noise_frame_mem0", mem[0], 32'hDEADBEEF);
    check("noise_frame_we_cnt", 32'(we_cnt - we_base), 1);
    check("noise_frame_done", 32'(done_cnt - done_base), 1);
    check("noise_frame_wcnt", 32'(word_count), 1);

    // Count byte out of range: 0 and 2^ADDR_W + 1
    mark();
    tx_q = {8'hA5, 8'h00};
    send_q();
    check("cnt0_err", 32'(load_err), 1);
    check("cnt0_hold", 32'(cpu_hold), 1);
    send_byte(8'hA5, 1'b1);
    check("cnt81_sync_clears", 32'(load_err), 0);
    send_byte(8'h81, 1'b1);
    check("cnt81_err", 32'(load_err), 1);
    check("cnt_we_cnt", 32'(we_cnt - we_base), 0);

    // Framing error on the third data byte
    mark();
    tx_q = {8'hA5, 8'h01, 8'h11, 8'h22};
    send_q();
    check("ferr_pre_err", 32'(load_err), 0);
    send_byte(8'h33, 1'b0);
    repeat (5) @(negedge clk);
    check("ferr_err", 32'(load_err), 1);
    check("ferr_we_cnt", 32'(we_cnt - we_base), 0);

    // Line goes quiet after two data bytes
    mark();
    tx_q = {8'hA5, 8'h01, 8'h11, 8'h22};
    send_q();
    check("to_pre_err", 32'(load_err), 0);
    cyc = 0;
    while (!load_err && cyc < 12000) begin
      @(negedge clk);
      cyc++;
    end
    check("to_err", 32'(load_err), 1);
    check("to_window", 32'(cyc >= 9990 && cyc <= 10010), 1);
    check("to_hold", 32'(cpu_hold), 1);
    check("to_we_cnt", 32'(we_cnt - we_base), 0);

    // Reset after word 0 of a two-word frame, then a fresh frame from address 0
    mark();
    tx_q = {8'hA5, 8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00};
    send_q();
    check("mid_we_cnt", 32'(we_cnt - we_base), 1);
    check("mid_mem0", mem[0], 32'h00500013);
    check("mid_wcnt", 32'(word_count), 1);
    rstn = 1'b0;
    #1 check_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    mark();
    tx_q = {8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_q();
    repeat (5) @(negedge clk);
    check("post_rst_mem0", mem[0], 32'hDEADBEEF);
    check("post_rst_we_cnt", 32'(we_cnt - we_base), 1);
    check("post_rst_done", 32'(done_cnt - done_base), 1);
    check("post_rst_hold", 32'(cpu_hold), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
